// File: rtl/adder_arb_pkg.sv
// Shared state encoding and sizing helper for the adder sharing arbiter.
package adder_arb_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  typedef enum logic {
    StIdle  = ST_IDLE,
    StGrant = ST_GRANT
  } arb_state_e;

  // Ceiling log2 with a floor of 1 so single-value ranges still get a bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin first-one search over the request vector, starting just after ptr_i.
module rr_picker #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [IDW-1:0]  pick_o,
  output logic            any_valid_o
);

  logic [IDW-1:0] idx;

  always_comb begin
    pick_o      = '0;
    any_valid_o = 1'b0;
    idx         = '0;
    // i runs 1..NREQ so the current pointer holder is checked last.
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = IDW'((32'(ptr_i) + i) % NREQ);
      if (!any_valid_o && valid_i[idx]) begin
        any_valid_o = 1'b1;
        pick_o      = idx;
      end
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Packet-locked round-robin sharing of one external combinational adder among NREQ sources,
// with a single-entry registered result carrying the producing requester id.
module adder_share_arbiter
  import adder_arb_pkg::*;
#(
  parameter int unsigned N         = 18,
  parameter int unsigned NREQ      = 4,
  parameter int unsigned IDW       = clog2(NREQ),
  parameter int unsigned MAX_BURST = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_last,
  input  logic [NREQ*N-1:0] req_op1,
  input  logic [NREQ*N-1:0] req_op2,
  output logic [NREQ-1:0]   req_ready,
  output logic [N-1:0]      add_in1,
  output logic [N-1:0]      add_in2,
  input  logic [N-1:0]      add_sum,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [N-1:0]      res_sum,
  output logic [IDW-1:0]    res_id,
  output logic              res_last
);

  localparam int unsigned CW = clog2(MAX_BURST);
  localparam logic [CW-1:0] LastCnt = CW'(MAX_BURST - 1);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [CW-1:0]  beat_cnt_q, beat_cnt_d;
  logic           res_valid_q, res_valid_d;
  logic [N-1:0]   res_sum_q, res_sum_d;
  logic [IDW-1:0] res_id_q, res_id_d;
  logic           res_last_q, res_last_d;

  logic [IDW-1:0] pick;
  logic           any_valid;
  logic           can_acc;
  logic           acc;
  logic           release_pkt;
  logic [N-1:0]   op1_arr [NREQ];
  logic [N-1:0]   op2_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign op1_arr[g] = req_op1[g*N +: N];
    assign op2_arr[g] = req_op2[g*N +: N];
  end

  rr_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_picker (
    .valid_i     (req_valid),
    .ptr_i       (rr_ptr_q),
    .pick_o      (pick),
    .any_valid_o (any_valid)
  );

  // Handshake and operand gating; operands stay at zero unless a beat is actually taken.
  always_comb begin
    can_acc     = !res_valid_q || res_ready;
    acc         = 1'b0;
    req_ready   = '0;
    add_in1     = '0;
    add_in2     = '0;
    release_pkt = 1'b0;
    if (state_q == StGrant) begin
      req_ready[owner_q] = can_acc;
      acc                = req_valid[owner_q] && can_acc;
    end
    if (acc) begin
      add_in1     = op1_arr[owner_q];
      add_in2     = op2_arr[owner_q];
      release_pkt = req_last[owner_q] || (beat_cnt_q == LastCnt);
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          owner_d    = pick;
          beat_cnt_d = '0;
          state_d    = StGrant;
        end
      end
      StGrant: begin
        if (acc) begin
          if (release_pkt) begin
            rr_ptr_d   = owner_q;
            beat_cnt_d = '0;
            state_d    = StIdle;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A new beat reloads the register even while the previous result is being taken.
  always_comb begin
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_id_d    = res_id_q;
    res_last_d  = res_last_q;
    if (acc) begin
      res_valid_d = 1'b1;
      res_sum_d   = add_sum;
      res_id_d    = owner_q;
      res_last_d  = req_last[owner_q];
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_ptr_q    <= IDW'(NREQ - 1);
      owner_q     <= '0;
      beat_cnt_q  <= '0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_id_q    <= '0;
      res_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      beat_cnt_q  <= beat_cnt_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_id_q    <= res_id_d;
      res_last_q  <= res_last_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_id    = res_id_q;
  assign res_last  = res_last_q;

endmodule
